ms_div: RTL and testbench
=========================

Name: ms_div

Overview:
- Sequential signed divider: the inverse companion to the team's sequential multiplier (ms_sim).
- Takes a 2(DW+1)-bit dividend (a multiplier product) and a (DW+1)-bit divisor from the switch bus.
- Returns quotient and remainder after a fixed multi-cycle restoring division.
- Uses the same start/ready handshake as the multiplier, so the two blocks swap freely behind the same switch/LED front end.

Parameters:
- DW, 8 (from pkg_mult): divisor MSB index; divisor is DW+1 = 9 bits, signed.
- DW2, 17 (from pkg_mult): dividend/quotient MSB index; 2*(DW+1) = 18 bits, signed.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  start request, active-low; a falling edge launches one operation.
- i_sw  in  DW2+DW+2 (27)  {dividend[DW2:0], divisor[DW:0]}, two's complement.
- o_quot  out  DW2+1  signed quotient.
- o_rem  out  DW+1  signed remainder.
- o_ready  out  1  high = idle, results valid.
- o_div0  out  1  high = last operation had divisor 0.

Behaviour:
- Reset (i_rst=0, async): state IDLE; o_quot=0, o_rem=0, o_div0=0, o_ready=1; start-edge flop = 1.
- Start detect: registered copy of i_start. A falling edge is previous=1, current=0, sampled on an i_clk rise. Holding i_start low gives exactly one trigger.
- FSM states and transitions:
  - IDLE: o_ready=1. A start edge goes to LOAD.
  - LOAD (1 cycle): latch i_sw; store operand signs and magnitudes (|dividend| 18 bits unsigned, |divisor| 9 bits unsigned); o_ready=0; iteration counter = DW2+1. Divisor 0 goes to DONE with div0; otherwise goes to DIV.
  - DIV (18 cycles): one restoring step per cycle. Shift {partial rem, dividend} left 1; trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1, else restore and set it to 0. Decrement the counter; counter 0 goes to FIX.
  - FIX (1 cycle): quotient negated if the signs differ; remainder takes the dividend's sign (truncate toward zero). Register o_quot/o_rem; o_div0=0; go to DONE.
  - DONE (1 cycle): o_ready=1; go to IDLE.
- Latency: edge sampled at rise k; o_ready falls at k+1 and rises at k+21. For div0 it rises at k+2.
- Div by zero: o_quot=0, o_rem=0, o_div0=1.
- Overflow: -131072 / -1 wraps to o_quot=-131072 (18-bit two's complement), o_rem=0. No flag is raised.
- Start edge while busy (LOAD/DIV/FIX/DONE): ignored; no queueing.
- i_sw changes after LOAD: no effect on the running operation.
- o_quot/o_rem/o_div0 hold their previous values while busy and update only in FIX/LOAD(div0).
- Reset mid-operation: immediate abort to the reset values. A start edge needs i_start high for at least one cycle after reset release.

Decomposition:
- pkg_mult gains:
  - DW, DW2 (shared with the multiplier);
  - typedef enum logic [2:0] div_state_e {IDLE, LOAD, DIV, FIX, DONE};
  - CNT_W = $clog2(DW2+2) counter width.
- One sub-module, start_fall_det: active-low start falling-edge detector (i_clk, i_rst, i_start, o_pulse). It is reused by the multiplier wrapper.
- The restoring step stays inline in ms_div.

Test Plan:
- After reset, dividend 65536, divisor -256, pulse i_start low 1 cycle -> o_ready low for 20 cycles, then o_quot=-256, o_rem=0, o_div0=0 (inverts the multiplier's -256*-256).
- Dividend 49, divisor 7 -> o_quot=7, o_rem=0; -50 / 7 -> o_quot=-7, o_rem=-1; 50 / -7 -> o_quot=-7, o_rem=1.
- Dividend 50, divisor 0 -> o_ready back high 2 cycles after the edge; o_div0=1, o_quot=0, o_rem=0. A following 10/3 clears o_div0 and gives o_quot=3, o_rem=1.
- Dividend -131072, divisor -1 -> o_quot=-131072, o_rem=0. Dividend 131071, divisor 1 -> o_quot=131071.
- Start 30 / 4. Re-pulse i_start at cycle 5 with i_sw changed to 99/9 -> result 7 rem 2 at cycle 21; the second pulse is ignored; i_start held low 40 cycles -> only one operation.
- Start 1000 / 3. Assert i_rst low at cycle 10 -> outputs 0, o_ready=1 immediately. After release and a new pulse, 1000/3 -> o_quot=333, o_rem=1.

Source files
------------

// File: rtl/pkg_mult.sv
// rtl/pkg_mult.sv - shared widths and divider state encoding for the multiply/divide pair
package pkg_mult;

    localparam int DW    = 8;
    localparam int DW2   = 17;
    localparam int CNT_W = $clog2(DW2 + 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/start_fall_det.sv
// rtl/start_fall_det.sv - falling-edge detector for the active-low start request
module start_fall_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_pulse
);

    logic start_q;

    // Previous start level; resets high so a start held low through reset does not fire
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            start_q <= 1'b1;
        end else begin
            start_q <= i_start;
        end
    end

    assign o_pulse = start_q & ~i_start;

endmodule

// File: rtl/ms_div.sv
// rtl/ms_div.sv - sequential signed restoring divider with start/ready handshake
module ms_div
    import pkg_mult::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DW2+DW+1:0]     i_sw,
    output logic signed [DW2:0]   o_quot,
    output logic signed [DW:0]    o_rem,
    output logic                  o_ready,
    output logic                  o_div0
);

    div_state_e        state;
    div_state_e        state_nxt;
    logic              start_pulse;
    logic              ready_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DW2:0]      quo_q;     // dividend magnitude shifting out, quotient bits shifting in
    logic [DW:0]       rem_q;     // partial remainder, always below the divisor magnitude
    logic [DW:0]       dmag_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic [DW2:0]      sw_dvd;
    logic [DW:0]       sw_dvs;
    logic [DW+1:0]     shifted;
    logic              fits;
    logic [DW:0]       rem_sub;

    assign sw_dvd = i_sw[DW2+DW+1:DW+1];
    assign sw_dvs = i_sw[DW:0];

    // One restoring step: bring in the next dividend bit and trial-subtract the divisor
    assign shifted = {rem_q, quo_q[DW2]};
    assign fits    = shifted >= {1'b0, dmag_q};
    assign rem_sub = shifted[DW:0] - dmag_q;

    start_fall_det u_start_det (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .o_pulse (start_pulse)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start edges outside IDLE are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_pulse) state_nxt = LOAD;
            LOAD:    state_nxt = (sw_dvs == '0) ? DONE : DIV;
            DIV:     if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready drops when operands are taken and returns in the completion cycle
    always_comb begin
        ready_nxt = o_ready;
        case (state)
            LOAD:    ready_nxt = 1'b0;
            DONE:    ready_nxt = 1'b1;
            default: ready_nxt = o_ready;
        endcase
    end

    // Datapath and result registers; results only change in FIX or on a divide by zero
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_ready   <= 1'b1;
            o_quot    <= '0;
            o_rem     <= '0;
            o_div0    <= 1'b0;
            cnt       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dmag_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            o_ready <= ready_nxt;
            case (state)
                LOAD: begin
                    quo_q     <= sw_dvd[DW2] ? -sw_dvd : sw_dvd;
                    dmag_q    <= sw_dvs[DW] ? -sw_dvs : sw_dvs;
                    neg_quo_q <= sw_dvd[DW2] ^ sw_dvs[DW];
                    neg_rem_q <= sw_dvd[DW2];
                    rem_q     <= '0;
                    cnt       <= CNT_W'(DW2 + 1);
                    if (sw_dvs == '0) begin
                        o_quot <= '0;
                        o_rem  <= '0;
                        o_div0 <= 1'b1;
                    end
                end
                DIV: begin
                    rem_q <= fits ? rem_sub : shifted[DW:0];
                    quo_q <= {quo_q[DW2-1:0], fits};
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    // Truncating division: remainder follows the dividend's sign
                    o_quot <= neg_quo_q ? -quo_q : quo_q;
                    o_rem  <= neg_rem_q ? -rem_q : rem_q;
                    o_div0 <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_div.sv
// tb/tb_ms_div.sv - self-checking bench for ms_div against a timeline/arithmetic model
module tb_ms_div;

    logic               i_clk;
    logic               i_rst;
    logic               i_start;
    logic [26:0]        i_sw;
    logic signed [17:0] o_quot;
    logic signed [8:0]  o_rem;
    logic               o_ready;
    logic               o_div0;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    ms_div dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_sw    (i_sw),
        .o_quot  (o_quot),
        .o_rem   (o_rem),
        .o_ready (o_ready),
        .o_div0  (o_div0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] pack(input int a, input int b);
        return {a[17:0], b[8:0]};
    endfunction

    // Model: an accepted start edge at rise k takes operands at k+1; results appear at
    // k+20 and ready returns at k+21 (k+2 with results at k+1 for a zero divisor).
    // Quotient/remainder come from integer truncating division, wrapped to port width.
    logic               m_prev;
    logic               m_ready;
    logic               m_div0;
    logic signed [17:0] m_quot;
    logic signed [8:0]  m_rem;
    int                 m_t;
    int                 m_end;
    int                 m_a;
    int                 m_b;

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_prev  <= 1'b1;
            m_ready <= 1'b1;
            m_div0  <= 1'b0;
            m_quot  <= '0;
            m_rem   <= '0;
            m_t     <= 0;
            m_end   <= 0;
        end else begin
            m_prev <= i_start;
            if (m_t == 0) begin
                if (m_prev && !i_start) m_t <= 1;
            end else begin
                if (m_t == 1) begin
                    m_a     <= $signed(i_sw[26:9]);
                    m_b     <= $signed(i_sw[8:0]);
                    m_end   <= (i_sw[8:0] == 9'd0) ? 2 : 21;
                    m_ready <= 1'b0;
                    if (i_sw[8:0] == 9'd0) begin
                        m_quot <= '0;
                        m_rem  <= '0;
                        m_div0 <= 1'b1;
                    end
                end
                if (m_t == 20 && m_b != 0) begin
                    m_quot <= 18'(m_a / m_b);
                    m_rem  <= 9'(m_a % m_b);
                    m_div0 <= 1'b0;
                end
                if (m_t != 1 && m_t == m_end) begin
                    m_ready <= 1'b1;
                    m_t     <= 0;
                end else begin
                    m_t <= m_t + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("ready", int'(o_ready), int'(m_ready));
            chk("quot",  int'(o_quot),  int'(m_quot));
            chk("rem",   int'(o_rem),   int'(m_rem));
            chk("div0",  int'(o_div0),  int'(m_div0));
        end
    end

    // Count negedges with ready low until it returns; bounded
    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_ready) return;
            lat++;
        end
        chk("ready_timeout", lat, -1);
    endtask

    task automatic do_op(input string tag, input int a, input int b, input int eq,
                         input int er, input int ed0, input int elat);
        int lat;
        @(negedge i_clk);
        i_sw    = pack(a, b);
        i_start = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        wait_ready(lat);
        chk({tag, "_lat"},  lat, elat);
        chk({tag, "_quot"}, int'(o_quot), eq);
        chk({tag, "_rem"},  int'(o_rem),  er);
        chk({tag, "_div0"}, int'(o_div0), ed0);
        chk({tag, "_model_quot"}, int'(m_quot), eq);
        chk({tag, "_model_rem"},  int'(m_rem),  er);
    endtask

    initial begin
        int lat;
        int falls;
        logic prev_rdy;

        i_rst   = 1'b0;
        i_start = 1'b1;
        i_sw    = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_quot",  int'(o_quot),  0);
        chk("rst_rem",   int'(o_rem),   0);
        chk("rst_div0",  int'(o_div0),  0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk_en = 1;

        do_op("inv_mul", 65536, -256, -256, 0, 0, 20);
        do_op("p49_7",   49, 7, 7, 0, 0, 20);
        do_op("n50_7",   -50, 7, -7, -1, 0, 20);
        do_op("p50_n7",  50, -7, -7, 1, 0, 20);
        do_op("div0",    50, 0, 0, 0, 1, 1);
        do_op("p10_3",   10, 3, 3, 1, 0, 20);
        do_op("ovf",     -131072, -1, -131072, 0, 0, 20);
        do_op("max_1",   131071, 1, 131071, 0, 0, 20);
        do_op("n255_n256", -255, -256, 0, -255, 0, 20);

        // Second start while busy, with new operands, is ignored
        @(negedge i_clk);
        i_sw    = pack(30, 4);
        i_start = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        repeat (3) @(negedge i_clk);
        i_sw    = pack(99, 9);
        i_start = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        wait_ready(lat);
        chk("busy_lat",  lat, 16);
        chk("busy_quot", int'(o_quot), 7);
        chk("busy_rem",  int'(o_rem),  2);
        repeat (25) @(negedge i_clk);
        chk("busy_no_queue", int'(o_quot), 7);

        // Start held low for 40 cycles gives a single operation
        @(negedge i_clk);
        i_sw     = pack(1000, 7);
        i_start  = 1'b0;
        falls    = 0;
        prev_rdy = o_ready;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (i == 39) i_start = 1'b1;
            if (prev_rdy && !o_ready) falls++;
            prev_rdy = o_ready;
        end
        chk("hold_ops",  falls, 1);
        chk("hold_quot", int'(o_quot), 142);
        chk("hold_rem",  int'(o_rem),  6);

        // Reset mid-operation aborts immediately
        @(negedge i_clk);
        i_sw    = pack(1000, 3);
        i_start = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        repeat (8) @(negedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        chk("abort_ready", int'(o_ready), 1);
        chk("abort_quot",  int'(o_quot),  0);
        chk("abort_rem",   int'(o_rem),   0);
        chk("abort_div0",  int'(o_div0),  0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        do_op("after_rst", 1000, 3, 333, 1, 0, 20);

        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
